// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller: the FSM state
// encoding and the ALU operand-forwarding select codes.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// fwd_select
// Operand forwarding compare for one ALU source register.
// Ports:
//   src_i          register number the EX-stage operand reads
//   mem_regwrite_i EX/MEM write-back enable, mem_rd_i its destination
//   wb_regwrite_i  MEM/WB write-back enable,  wb_rd_i its destination
//   sel_o          FWD_RF / FWD_EXMEM / FWD_MEMWB
module fwd_select
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic       mem_regwrite_i,
    input  logic [4:0] mem_rd_i,
    input  logic       wb_regwrite_i,
    input  logic [4:0] wb_rd_i,
    output logic [1:0] sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (wb_regwrite_i && (wb_rd_i != 5'd0) && (wb_rd_i == src_i)) begin
            sel_o = FWD_MEMWB;
        end
        // The younger EX/MEM result takes precedence over MEM/WB.
        if (mem_regwrite_i && (mem_rd_i != 5'd0) && (mem_rd_i == src_i)) begin
            sel_o = FWD_EXMEM;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard controller: load-use stall, branch flush, halt drain and
// ALU operand forwarding, with saturating stall/flush event counters.
// Ports:
//   clk, rst                 clock, async active-high reset
//   id_rs, id_rt, id_uses_rt source registers of the instruction in ID
//   ex_memread, ex_rd        load in ID/EX and its destination
//   mem_regwrite, mem_rd     EX/MEM write-back
//   wb_regwrite, wb_rd       MEM/WB write-back
//   pcsrc                    taken branch resolved in MEM
//   halt_req                 level request to drain and freeze
//   pc_write, ifid_write     register enables
//   idex_bubble              zero ID/EX control fields
//   ifid/idex/exmem_flush    squash stage contents
//   fwd_a, fwd_b             ALU operand selects
//   halted                   pipeline empty and frozen
//   stall_cnt, flush_cnt     saturating event counters
//
// state       | meaning
// ST_RUN      | normal issue, hazards checked every cycle
// ST_LD_STALL | the one cycle after a load-use bubble, no re-stall
// ST_DRAIN    | bubbling the pipeline empty, drain_q cycles left
// ST_HALTED   | pipeline empty and frozen until halt_req drops
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_rd,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic             pcsrc,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [4:0]       rs_q, rs_d, rt_q, rt_d;
    logic             load_use, flush_all, stall_ev;

    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        flush_all   = 1'b0;
        stall_ev    = 1'b0;

        if (state_q == ST_HALTED) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (!halt_req) state_d = ST_RUN;
        end else if (pcsrc) begin
            // A taken branch overrides every other action; a pending halt
            // restarts its drain since the redirect refills the front end.
            flush_all = 1'b1;
            if (halt_req) begin
                state_d = ST_DRAIN;
                drain_d = DRAIN_LOAD;
            end else begin
                state_d = ST_RUN;
                drain_d = '0;
            end
        end else if (state_q == ST_DRAIN) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (!halt_req) begin
                state_d = ST_RUN;
                drain_d = '0;
            end else if (drain_q <= DW'(1)) begin
                state_d = ST_HALTED;
                drain_d = '0;
            end else begin
                drain_d = drain_q - 1'b1;
            end
        end else if (state_q == ST_LD_STALL) begin
            state_d = ST_RUN;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_ev    = 1'b1;
            state_d     = ST_LD_STALL;
        end else if (halt_req) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_LOAD;
        end

        // Hold the pipeline in plain run mode while reset is asserted.
        if (rst) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_bubble = 1'b0;
            flush_all   = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_ev && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        flush_cnt_d = flush_cnt_q;
        if (flush_all && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;

        rs_d = (idex_bubble || flush_all) ? 5'd0 : id_rs;
        rt_d = (idex_bubble || flush_all) ? 5'd0 : id_rt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            drain_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            rs_q        <= 5'd0;
            rt_q        <= 5'd0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
        end
    end

    assign ifid_flush  = flush_all;
    assign idex_flush  = flush_all;
    assign exmem_flush = flush_all;
    assign halted      = (state_q == ST_HALTED);
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

    fwd_select u_fwd_a (
        .src_i          (rs_q),
        .mem_regwrite_i (mem_regwrite),
        .mem_rd_i       (mem_rd),
        .wb_regwrite_i  (wb_regwrite),
        .wb_rd_i        (wb_rd),
        .sel_o          (fwd_a)
    );

    fwd_select u_fwd_b (
        .src_i          (rt_q),
        .mem_regwrite_i (mem_regwrite),
        .mem_rd_i       (mem_rd),
        .wb_regwrite_i  (wb_regwrite),
        .wb_rd_i        (wb_rd),
        .sel_o          (fwd_b)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: forwarding vector table, hand-written hazard
// sequences, and randomized traffic checked against a rule-level model.
module tb_hazard_ctrl;

    localparam int CW = 4;
    localparam int DC = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic          id_uses_rt, ex_memread, mem_regwrite, wb_regwrite;
    logic          pcsrc, halt_req;
    logic          pc_write, ifid_write, idex_bubble;
    logic          ifid_flush, idex_flush, exmem_flush, halted;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.CNT_W(CW), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rd(ex_rd),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .pcsrc(pcsrc), .halt_req(halt_req),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: pipeline situation described by plain flags.
    bit         m_frozen, m_draining, m_after_stall;
    int         m_drain_left, m_stalls, m_flushes;
    int         m_rs, m_rt;
    bit         e_pc, e_ifid, e_bub, e_fl, e_halted;

    task automatic model_reset();
        m_frozen = 0; m_draining = 0; m_after_stall = 0;
        m_drain_left = 0; m_stalls = 0; m_flushes = 0; m_rs = 0; m_rt = 0;
    endtask

    function automatic bit hit_load_use();
        return ex_memread && ex_rd != 0 &&
               (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
    endfunction

    function automatic int fwd_ref(input int src);
        if (mem_regwrite && mem_rd != 0 && int'(mem_rd) == src) return 2;
        if (wb_regwrite && wb_rd != 0 && int'(wb_rd) == src) return 1;
        return 0;
    endfunction

    task automatic set_in(input int rs, input int rt, input bit uses_rt,
                          input bit memread, input int exrd,
                          input bit mrw, input int mrd, input bit wrw, input int wrd,
                          input bit pcs, input bit hlt);
        id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = uses_rt;
        ex_memread = memread; ex_rd = 5'(exrd);
        mem_regwrite = mrw; mem_rd = 5'(mrd); wb_regwrite = wrw; wb_rd = 5'(wrd);
        pcsrc = pcs; halt_req = hlt;
    endtask

    // Called at posedge+1 with inputs applied; compares mid-cycle.
    task automatic sample();
        #4;
        e_fl = 0; e_halted = 0;
        if (m_frozen) begin
            e_pc = 0; e_ifid = 0; e_bub = 1; e_halted = 1;
        end else if (pcsrc) begin
            e_pc = 1; e_ifid = 1; e_bub = 0; e_fl = 1;
        end else if (m_draining) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
        end else if (!m_after_stall && hit_load_use()) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
        end else begin
            e_pc = 1; e_ifid = 1; e_bub = 0;
        end
        check("pc_write", pc_write, e_pc);
        check("ifid_write", ifid_write, e_ifid);
        check("idex_bubble", idex_bubble, e_bub);
        check("ifid_flush", ifid_flush, e_fl);
        check("idex_flush", idex_flush, e_fl);
        check("exmem_flush", exmem_flush, e_fl);
        check("halted", halted, e_halted);
        check("fwd_a", fwd_a, fwd_ref(m_rs));
        check("fwd_b", fwd_b, fwd_ref(m_rt));
        check("stall_cnt", stall_cnt, m_stalls);
        check("flush_cnt", flush_cnt, m_flushes);
    endtask

    task automatic advance();
        if (m_frozen) begin
            m_frozen = halt_req;
        end else if (pcsrc) begin
            if (m_flushes < CMAX) m_flushes++;
            m_after_stall = 0;
            m_draining = halt_req;
            m_drain_left = DC;
        end else if (m_draining) begin
            if (!halt_req) m_draining = 0;
            else if (m_drain_left <= 1) begin m_draining = 0; m_frozen = 1; end
            else m_drain_left--;
        end else if (m_after_stall) begin
            m_after_stall = 0;
        end else if (hit_load_use()) begin
            m_after_stall = 1;
            if (m_stalls < CMAX) m_stalls++;
        end else if (halt_req) begin
            m_draining = 1;
            m_drain_left = DC;
        end
        m_rs = (e_bub || e_fl) ? 0 : int'(id_rs);
        m_rt = (e_bub || e_fl) ? 0 : int'(id_rt);
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    typedef struct {
        int rs, rt;
        bit mrw; int mrd;
        bit wrw; int wrd;
        int ea, eb;
    } fwd_vec_t;

    fwd_vec_t vecs[8];
    int bubbles;
    bit seen_halt;

    initial begin
        vecs[0] = '{5, 3, 1, 5, 1, 5, 2, 0};
        vecs[1] = '{5, 3, 0, 5, 1, 5, 1, 0};
        vecs[2] = '{5, 3, 1, 0, 1, 0, 0, 0};
        vecs[3] = '{0, 0, 1, 0, 1, 0, 0, 0};
        vecs[4] = '{7, 7, 1, 7, 1, 7, 2, 2};
        vecs[5] = '{1, 2, 1, 2, 1, 1, 1, 2};
        vecs[6] = '{9, 9, 0, 9, 0, 9, 0, 0};
        vecs[7] = '{4, 6, 1, 3, 1, 6, 0, 1};

        // Reset with hazard-provoking inputs: outputs must sit at defaults.
        rst = 1'b1;
        set_in(2, 2, 1, 1, 2, 1, 2, 1, 2, 1, 1);
        #2;
        check("rst_pc_write", pc_write, 1);
        check("rst_ifid_write", ifid_write, 1);
        check("rst_bubble", idex_bubble, 0);
        check("rst_flush", ifid_flush | idex_flush | exmem_flush, 0);
        check("rst_fwd_a", fwd_a, 0);
        check("rst_halted", halted, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Forwarding table: load rs/rt one cycle, check selects the next.
        foreach (vecs[i]) begin
            set_in(vecs[i].rs, vecs[i].rt, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            step();
            set_in(vecs[i].rs, vecs[i].rt, 1, 0, 0,
                   vecs[i].mrw, vecs[i].mrd, vecs[i].wrw, vecs[i].wrd, 0, 0);
            sample();
            check($sformatf("vec%0d_fwd_a", i), fwd_a, vecs[i].ea);
            check($sformatf("vec%0d_fwd_b", i), fwd_b, vecs[i].eb);
            advance();
        end

        // lw $2 in EX, ID reads $2: one stall cycle.
        set_in(2, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0);
        sample();
        check("lu_pc_write", pc_write, 0);
        check("lu_bubble", idex_bubble, 1);
        advance();
        set_in(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sample();
        check("lu_after_pc_write", pc_write, 1);
        check("lu_stall_cnt", stall_cnt, 1);
        advance();

        // Branch taken together with a load-use hit: flush wins.
        set_in(3, 0, 0, 1, 3, 0, 0, 0, 0, 1, 0);
        sample();
        check("br_flush", ifid_flush & idex_flush & exmem_flush, 1);
        check("br_pc_write", pc_write, 1);
        check("br_bubble", idex_bubble, 0);
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sample();
        check("br_flush_cnt", flush_cnt, 1);
        check("br_stall_cnt", stall_cnt, 1);
        advance();

        // Halt held: count bubble cycles before halted, then release.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        bubbles = 0;
        seen_halt = 0;
        for (int c = 0; c < 20 && !seen_halt; c++) begin
            sample();
            if (halted) seen_halt = 1;
            else if (idex_bubble) bubbles++;
            advance();
        end
        check("halt_bubbles", bubbles, DC);
        check("halt_reached", seen_halt, 1);
        halt_req = 1'b0;
        sample();
        check("halt_release_hold", pc_write, 0);
        advance();
        sample();
        check("halt_release_pc_write", pc_write, 1);
        advance();

        // Reset pulsed during the second drain cycle.
        halt_req = 1'b1;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check("rst_drain_pc_write", pc_write, 1);
        check("rst_drain_halted", halted, 0);
        check("rst_drain_bubble", idex_bubble, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        halt_req = 1'b0;
        model_reset();
        sample();
        check("post_rst_pc_write", pc_write, 1);
        advance();

        // Saturation of stall_cnt by repeated stalls.
        for (int k = 0; k < CMAX + 3; k++) begin
            set_in(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
            step();
            set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
        sample();
        check("stall_cnt_saturated", stall_cnt, CMAX);
        advance();

        // Randomized traffic against the model.
        halt_req = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_uses_rt   = 1'($urandom_range(0, 1));
            ex_memread   = 1'($urandom_range(0, 1));
            ex_rd        = 5'($urandom_range(0, 3));
            mem_regwrite = 1'($urandom_range(0, 1));
            mem_rd       = 5'($urandom_range(0, 3));
            wb_regwrite  = 1'($urandom_range(0, 1));
            wb_rd        = 5'($urandom_range(0, 3));
            pcsrc        = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 29) == 0) halt_req = ~halt_req;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 4, number of bubble cycles needed to empty the pipeline on halt.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 id_rs, id_rt  in  5 each  source registers of the instruction in IF/ID.
REQ-006 id_uses_rt  in  1  instruction in ID reads rt as an operand (not only as a destination).
REQ-007 ex_memread, ex_rd  in  1, 5  ID/EX load flag and its destination register.
REQ-008 mem_regwrite, mem_rd  in  1, 5  EX/MEM write-back enable and register.
REQ-009 wb_regwrite, wb_rd  in  1, 5  MEM/WB write-back enable and register.
REQ-010 pcsrc  in  1  branch taken, resolved in the MEM stage.
REQ-011 halt_req  in  1  level request to drain and freeze the pipeline.
REQ-012 pc_write, ifid_write  out  1 each  enables for the PC and IF/ID registers.
REQ-013 idex_bubble  out  1  zero the ID/EX control fields this cycle.
REQ-014 ifid_flush, idex_flush, exmem_flush  out  1 each  squash the stage contents.
REQ-015 fwd_a, fwd_b  out  2 each  ALU operand select: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
REQ-016 halted  out  1  pipeline is empty and frozen.
REQ-017 stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-018 SHALL implement the FSM states RUN, LD_STALL, DRAIN and HALTED.
REQ-019 Load-use SHALL be detected when ex_memread=1, ex_rd!=0, and either ex_rd==id_rs or (id_uses_rt and ex_rd==id_rt).
REQ-020 In RUN with load-use and pcsrc=0: pc_write=0, ifid_write=0 and idex_bubble=1 in that same cycle; the FSM then goes to LD_STALL.
REQ-021 LD_STALL SHALL last exactly one cycle with all enables at 1, after which the FSM returns to RUN; a second stall is never issued for the same load.
REQ-022 pcsrc=1 in any state except HALTED SHALL assert ifid_flush, idex_flush and exmem_flush in the same cycle, keep pc_write=1 and override any load-use stall; the FSM then goes to RUN, or to DRAIN if halt_req=1.
REQ-023 In RUN with halt_req=1 and no pcsrc: go to DRAIN and load the drain counter with DRAIN_CYCLES.
REQ-024 In DRAIN: pc_write=0, ifid_write=0, idex_bubble=1 and the counter decrements each cycle; when the counter reaches 0 the FSM goes to HALTED.
REQ-025 Deasserting halt_req during DRAIN SHALL return the FSM to RUN on the next edge, with no further bubbles.
REQ-026 In HALTED: halted=1, pc_write=0, ifid_write=0 and idex_bubble=1; halt_req=0 returns to RUN.
REQ-027 Forwarding A SHALL select 10 when mem_regwrite=1, mem_rd!=0 and mem_rd==rs; otherwise 01 when the same test holds on the WB fields; otherwise 00. The EX/MEM source wins when both match.
REQ-028 Forwarding B SHALL use the same rule on rt.
REQ-029 rs and rt for forwarding SHALL be the values registered from id_rs and id_rt when ID/EX loads; they are cleared on a bubble or flush.
REQ-030 stall_cnt SHALL increment by 1 per load-use stall cycle and flush_cnt by 1 per pcsrc cycle; both saturate at all-ones and never wrap.
REQ-031 Register $0 SHALL never cause a stall or a forward.

Reset
REQ-032 While rst=1: state=RUN, drain counter=0, stall_cnt=0, flush_cnt=0, registered rs and rt = 0.
REQ-033 While rst=1 the outputs SHALL be pc_write=1, ifid_write=1, all flush and bubble outputs 0, fwd=00 and halted=0.
REQ-034 Reset asserted mid-DRAIN or mid-LD_STALL SHALL abort the operation immediately, with no residual bubble.

Structure
REQ-035 The FSM state encoding and the fwd select constants (FWD_RF, FWD_EXMEM, FWD_MEMWB) SHALL live in a shared package.
REQ-036 The forwarding compare SHALL be one sub-module, fwd_select, instantiated once per operand.

Verification
REQ-037 Scenario: lw $2 in EX, ID reads rs=$2 -> one cycle with pc_write=0 and idex_bubble=1, then enables return to 1 and stall_cnt=1.
REQ-038 Scenario: pcsrc=1 in the same cycle as a load-use hit -> the three flushes are asserted, pc_write=1, no stall, flush_cnt increments and stall_cnt does not.
REQ-039 Scenario: mem_rd=wb_rd=$5, both regwrite=1, rs=$5 -> fwd_a=10; with mem_regwrite=0 -> fwd_a=01; with rd=$0 -> fwd_a=00.
REQ-040 Scenario: halt_req held -> exactly 4 bubble cycles, then halted=1; release -> pc_write=1 on the next cycle.
REQ-041 Scenario: rst pulsed during the 2nd DRAIN cycle -> pc_write=1 and halted=0 asynchronously; state RUN after release.
REQ-042 Scenario: stall_cnt preset near all-ones by repeated stalls -> holds at all-ones on further stalls.
